// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the shared-register arbiter.
// Imported by the arbiter top and its round-robin picker.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    localparam int ERR_CNT_W = 8;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(
        input logic [ERR_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Round-robin picker: rotate by ptr, take the lowest set bit,
// then rotate the winner back into requester numbering.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx
);

    localparam logic [IW:0] NQ = (IW+1)'(NREQ);

    logic [NREQ-1:0] rot;
    logic [IW-1:0]   enc;
    logic            found;
    logic [IW:0]     j;
    logic [IW:0]     s;

    // Rotate, priority-encode from bit 0, and un-rotate modulo NREQ.
    always_comb begin
        rot   = '0;
        enc   = '0;
        found = 1'b0;
        j     = '0;
        s     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = (IW+1)'(i) + {1'b0, ptr};
            if (j >= NQ) begin
                j = j - NQ;
            end
            rot[i] = req[j[IW-1:0]];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                enc   = IW'(i);
            end
        end
        s = {1'b0, enc} + {1'b0, ptr};
        if (s >= NQ) begin
            s = s - NQ;
        end
        any    = |req;
        idx    = s[IW-1:0];
        onehot = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Serialises load/clear requests onto one shared en/sclr register
// and confirms each write by reading the register back.
module reg_share_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  sclr,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       clr_op,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic                  busy,
    output logic                  reg_en,
    output logic                  reg_sclr,
    output logic [WIDTH-1:0]      reg_d,
    input  logic [WIDTH-1:0]      reg_q
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   next_ptr;
    logic            op;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] expected;

    logic            pick_any;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign next_ptr = (idx == IW'(NREQ-1)) ? '0 : idx + 1'b1;

    // Transaction FSM: latch the winner at grant, release it after CHECK.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state   <= IDLE;
            ptr     <= '0;
            idx     <= '0;
            op      <= OP_LOAD;
            data    <= '0;
            gnt     <= '0;
            err_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        idx   <= pick_idx;
                        op    <= clr_op[pick_idx];
                        data  <= wdata[pick_idx*WIDTH +: WIDTH];
                        gnt   <= pick_oh;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    state <= IDLE;
                    gnt   <= '0;
                    ptr   <= next_ptr;
                    if (err) begin
                        err_cnt <= sat_inc(err_cnt);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore decode of register drive, ack and read-back check.
    always_comb begin
        reg_en   = 1'b0;
        reg_sclr = 1'b0;
        reg_d    = '0;
        ack      = '0;
        err      = 1'b0;
        busy     = (state != IDLE);
        expected = (op == OP_LOAD) ? data : '0;
        unique case (1'b1)
            (state == WRITE): begin
                reg_en   = 1'b1;
                reg_sclr = (op == OP_CLEAR);
                reg_d    = data;
            end
            (state == CHECK): begin
                ack = NREQ'(1) << idx;
                err = (reg_q != expected);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter with a model of the
// shared register, directed vectors and a randomized reference run.
module tb_reg_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic        clk = 1'b0;
    logic        sclr;
    logic [3:0]  req;
    logic [3:0]  clr_op;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        err;
    logic [7:0]  err_cnt;
    logic        busy;
    logic        reg_en;
    logic        reg_sclr;
    logic [3:0]  reg_d;
    logic [3:0]  reg_q;

    logic        fault = 1'b0;
    logic [3:0]  q = 4'h0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  clr;
        logic [15:0] wdata;
        logic [3:0]  gnt;
        logic        sclr;
        logic [3:0]  d;
    } rec_t;

    rec_t tbl [7];

    reg_share_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .sclr     (sclr),
        .req      (req),
        .clr_op   (clr_op),
        .wdata    (wdata),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .err_cnt  (err_cnt),
        .busy     (busy),
        .reg_en   (reg_en),
        .reg_sclr (reg_sclr),
        .reg_d    (reg_d),
        .reg_q    (reg_q)
    );

    always #5 clk = ~clk;

    // Shared en/sclr register; in fault mode it ignores en and reads 0.
    always @(posedge clk) begin
        if (fault) begin
            q <= 4'h0;
        end else if (reg_en) begin
            q <= reg_sclr ? 4'h0 : reg_d;
        end
    end
    assign reg_q = q;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One transaction from an idle negedge through to the next idle.
    task automatic txn(input logic [3:0] r, input logic [3:0] c,
                       input logic [15:0] w, input logic [3:0] eg,
                       input logic es, input logic [3:0] ed,
                       input logic ee, input logic [3:0] eq);
        req    = r;
        clr_op = c;
        wdata  = w;
        @(negedge clk);
        chk("c1_gnt", 32'(gnt), 32'(eg));
        chk("c1_reg_en", 32'(reg_en), 32'd1);
        chk("c1_reg_sclr", 32'(reg_sclr), 32'(es));
        chk("c1_reg_d", 32'(reg_d), 32'(ed));
        chk("c1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("c2_ack", 32'(ack), 32'(eg));
        chk("c2_err", 32'(err), 32'(ee));
        chk("c2_reg_q", 32'(reg_q), 32'(eq));
        chk("c2_reg_en", 32'(reg_en), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("c3_busy", 32'(busy), 32'd0);
        chk("c3_err", 32'(err), 32'd0);
        chk("c3_ack", 32'(ack), 32'd0);
        chk("c3_gnt", 32'(gnt), 32'd0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt"}, 32'(gnt), 32'd0);
        chk({nm, "_ack"}, 32'(ack), 32'd0);
        chk({nm, "_err"}, 32'(err), 32'd0);
        chk({nm, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_reg_en"}, 32'(reg_en), 32'd0);
        chk({nm, "_reg_sclr"}, 32'(reg_sclr), 32'd0);
        chk({nm, "_reg_d"}, 32'(reg_d), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    logic [3:0] fair_exp [5];
    logic [3:0] ack_oh [5];
    int         ack_t [5];
    int         nack;
    int         c;

    int         ph;
    int         m_ptr;
    int         m_idx;
    int         m_cnt;
    logic       m_op;
    logic [3:0] m_data;
    logic [3:0] reqv;
    logic       found;
    logic [3:0] e_gnt;
    logic [3:0] e_ack;
    logic       e_err;
    logic [3:0] e_q;

    initial begin
        tbl[0] = '{4'b0001, 4'b0000, 16'h000A, 4'b0001, 1'b0, 4'hA};
        tbl[1] = '{4'b0010, 4'b0000, 16'h0050, 4'b0010, 1'b0, 4'h5};
        tbl[2] = '{4'b0100, 4'b0100, 16'h0300, 4'b0100, 1'b1, 4'h3};
        tbl[3] = '{4'b1111, 4'b0000, 16'h4321, 4'b1000, 1'b0, 4'h4};
        tbl[4] = '{4'b0110, 4'b0000, 16'h9876, 4'b0010, 1'b0, 4'h7};
        tbl[5] = '{4'b0011, 4'b0000, 16'hBCDE, 4'b0001, 1'b0, 4'hE};
        tbl[6] = '{4'b1000, 4'b1000, 16'hF000, 4'b1000, 1'b1, 4'hF};
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        sclr   = 1'b1;
        req    = 4'b0000;
        clr_op = 4'b0000;
        wdata  = 16'h0000;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        sclr = 1'b0;
        @(negedge clk);
        chk_zero("idle");

        for (int k = 0; k < 7; k++) begin
            txn(tbl[k].req, tbl[k].clr, tbl[k].wdata, tbl[k].gnt,
                tbl[k].sclr, tbl[k].d, 1'b0,
                tbl[k].sclr ? 4'h0 : tbl[k].d);
        end

        req    = 4'b1111;
        clr_op = 4'b0000;
        wdata  = 16'h1234;
        nack   = 0;
        c      = 0;
        while (nack < 5 && c < 20) begin
            @(negedge clk);
            c++;
            if (ack != 4'b0000) begin
                chk("fair_gnt_eq_ack", 32'(gnt), 32'(ack));
                ack_oh[nack] = ack;
                ack_t[nack]  = c;
                nack++;
            end
        end
        req = 4'b0000;
        @(negedge clk);
        chk("fair_nack", 32'(nack), 32'd5);
        if (nack > 0) begin
            chk("fair_first_latency", 32'(ack_t[0]), 32'd2);
        end
        for (int i = 0; i < nack; i++) begin
            chk("fair_order", 32'(ack_oh[i]), 32'(fair_exp[i]));
            if (i > 0) begin
                chk("fair_spacing", 32'(ack_t[i] - ack_t[i-1]), 32'd3);
            end
        end

        req   = 4'b0100;
        wdata = 16'h0900;
        @(negedge clk);
        chk("wd_gnt", 32'(gnt), 32'b0100);
        req = 4'b0000;
        @(negedge clk);
        chk("wd_ack", 32'(ack), 32'b0100);
        chk("wd_err", 32'(err), 32'd0);
        chk("wd_reg_q", 32'(reg_q), 32'h9);
        @(negedge clk);
        chk("wd_busy", 32'(busy), 32'd0);

        fault = 1'b1;
        chk("flt_cnt0", 32'(err_cnt), 32'd0);
        txn(4'b0001, 4'b0000, 16'h0007, 4'b0001, 1'b0, 4'h7, 1'b1, 4'h0);
        chk("flt_cnt1", 32'(err_cnt), 32'd1);
        for (int k = 2; k <= 300; k++) begin
            txn(4'b0001, 4'b0000, 16'h0007, 4'b0001, 1'b0, 4'h7,
                1'b1, 4'h0);
            if (k == 254) chk("flt_cnt254", 32'(err_cnt), 32'd254);
            if (k == 255) chk("flt_cnt255", 32'(err_cnt), 32'd255);
        end
        chk("flt_cnt_sat", 32'(err_cnt), 32'd255);
        fault = 1'b0;

        req    = 4'b0010;
        clr_op = 4'b0000;
        wdata  = 16'h00C0;
        @(negedge clk);
        chk("rw_c1_en", 32'(reg_en), 32'd1);
        sclr = 1'b1;
        req  = 4'b0000;
        @(negedge clk);
        chk_zero("rw_c2");
        chk("rw_write_kept", 32'(reg_q), 32'hC);
        sclr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rw_no_ack", 32'(ack), 32'd0);
            chk("rw_idle", 32'(busy), 32'd0);
        end
        txn(4'b1001, 4'b0000, 16'h2001, 4'b0001, 1'b0, 4'h1, 1'b0, 4'h1);
        txn(4'b1000, 4'b0000, 16'h6000, 4'b1000, 1'b0, 4'h6, 1'b0, 4'h6);

        ph    = 0;
        m_ptr = 0;
        m_idx = 0;
        m_cnt = 0;
        m_op  = 1'b0;
        m_data = 4'h0;
        reqv  = 4'b0000;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            e_gnt = (ph != 0) ? 4'(1 << m_idx) : 4'b0000;
            e_ack = (ph == 2) ? 4'(1 << m_idx) : 4'b0000;
            e_err = (ph == 2) && fault && !m_op && (m_data != 4'h0);
            e_q   = (fault || m_op) ? 4'h0 : m_data;
            chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
            chk("rnd_ack", 32'(ack), 32'(e_ack));
            chk("rnd_err", 32'(err), 32'(e_err));
            chk("rnd_busy", 32'(busy), 32'(ph != 0));
            chk("rnd_reg_en", 32'(reg_en), 32'(ph == 1));
            chk("rnd_reg_sclr", 32'(reg_sclr), 32'(ph == 1 && m_op));
            chk("rnd_reg_d", 32'(reg_d), (ph == 1) ? 32'(m_data) : 32'd0);
            chk("rnd_err_cnt", 32'(err_cnt), 32'(m_cnt));
            if (ph == 2) chk("rnd_reg_q", 32'(reg_q), 32'(e_q));

            for (int i = 0; i < 4; i++) begin
                if (!reqv[i] && $urandom_range(3) == 0) reqv[i] = 1'b1;
            end
            if (ph == 2) reqv[m_idx] = 1'b0;
            if (ph == 1 && $urandom_range(7) == 0) reqv[m_idx] = 1'b0;
            if (ph == 0) fault = ($urandom_range(3) == 0);
            req    = reqv;
            clr_op = 4'($urandom);
            wdata  = 16'($urandom);

            if (ph == 2) begin
                if (e_err && m_cnt < 255) m_cnt++;
                m_ptr = (m_idx + 1) % 4;
                ph    = 0;
            end else if (ph == 1) begin
                ph = 2;
            end else if (reqv != 4'b0000) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && reqv[(m_ptr + k) % 4]) begin
                        found = 1'b1;
                        m_idx = (m_ptr + k) % 4;
                    end
                end
                m_op   = clr_op[m_idx];
                m_data = wdata[m_idx*4 +: 4];
                ph     = 1;
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
